// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified-memory signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          IReqF;
  logic [AW-1:0] IAddrF;
  logic [31:0]   IRdataF;
  logic          IReadyF;
  logic          StallF;

  logic          DReqM;
  logic          DWeM;
  logic [AW-1:0] DAddrM;
  logic [31:0]   DWdataM;
  logic [31:0]   DRdataM;
  logic          DReadyM;
  logic          StallM;

  logic          MemEn;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWdata;
  logic [31:0]   MemRdata;

  modport slave (
    input  IReqF, IAddrF, DReqM, DWeM, DAddrM, DWdataM, MemRdata,
    output IRdataF, IReadyF, StallF, DRdataM, DReadyM, StallM,
           MemEn, MemWe, MemAddr, MemWdata
  );

  modport master (
    output IReqF, IAddrF, DReqM, DWeM, DAddrM, DWdataM, MemRdata,
    input  IRdataF, IReadyF, StallF, DRdataM, DReadyM, StallM,
           MemEn, MemWe, MemAddr, MemWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage,
// running fixed-latency accesses with round-robin fairness and pipeline stalls.
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] LAT_C = 8'(LAT);

  typedef enum logic [2:0] {
    IDLE,
    IBUSY,
    DBUSY,
    IDONE,
    DDONE
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    count_reg, count_next;
  logic          last_d_reg, last_d_next;
  logic          mem_en_reg, mem_en_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [31:0]   irdata_reg, irdata_next;
  logic [31:0]   drdata_reg, drdata_next;
  logic          grant_d, grant_i;

  // Data wins a tie unless it won the previous tie-free or tied grant.
  assign grant_d = bus.DReqM & (~bus.IReqF | ~last_d_reg);
  assign grant_i = bus.IReqF & ~grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      last_d_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      irdata_reg    <= '0;
      drdata_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      last_d_reg    <= last_d_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      irdata_reg    <= irdata_next;
      drdata_reg    <= drdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    last_d_next    = last_d_reg;
    mem_en_next    = mem_en_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    irdata_next    = irdata_reg;
    drdata_next    = drdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next     = DBUSY;
          mem_en_next    = 1'b1;
          mem_we_next    = bus.DWeM;
          mem_addr_next  = bus.DAddrM;
          mem_wdata_next = bus.DWdataM;
          count_next     = 8'd1;
          last_d_next    = 1'b1;
        end else if (grant_i) begin
          state_next    = IBUSY;
          mem_en_next   = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = bus.IAddrF;
          count_next    = 8'd1;
          last_d_next   = 1'b0;
        end
      end

      IBUSY, DBUSY: begin
        if (count_reg == LAT_C) begin
          mem_en_next = 1'b0;
          mem_we_next = 1'b0;
          if (state_reg == IBUSY) begin
            irdata_next = bus.MemRdata;
            state_next  = IDONE;
          end else begin
            // Stores leave the load-data register untouched.
            if (!mem_we_reg) begin
              drdata_next = bus.MemRdata;
            end
            state_next = DDONE;
          end
        end else begin
          count_next = count_reg + 8'd1;
        end
      end

      // One-cycle completion slot so a still-held request is not re-granted.
      IDONE, DDONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.IReadyF  = (state_reg == IDONE);
  assign bus.DReadyM  = (state_reg == DDONE);
  assign bus.StallF   = bus.IReqF & ~bus.IReadyF;
  assign bus.StallM   = bus.DReqM & ~bus.DReadyM;
  assign bus.IRdataF  = irdata_reg;
  assign bus.DRdataM  = drdata_reg;
  assign bus.MemEn    = mem_en_reg;
  assign bus.MemWe    = mem_we_reg;
  assign bus.MemAddr  = mem_addr_reg;
  assign bus.MemWdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts grant order, timing and data; a monitor compares every cycle.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 32;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          store;
  } exp_t;

  logic clk;
  logic reset;
  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.LAT(LAT), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  exp_t i_q[$];
  exp_t d_q[$];

  int          cyc;
  int          free_cyc;
  bit          last_d;
  bit          mon_on = 1'b0;
  int          win_lo, win_hi;
  bit          exp_we;
  logic [31:0] exp_memaddr, exp_memwdata, exp_irdata, exp_drdata;
  bit          rnd_busy;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory: combinational read, writes whenever a write access is enabled.
  assign bus.MemRdata = bus.MemEn ? mem[bus.MemAddr[9:2]] : 32'h0bad_f00d;

  initial begin
    forever begin
      @(posedge clk);
      if (bus.MemEn === 1'b1 && bus.MemWe === 1'b1) mem[bus.MemAddr[9:2]] = bus.MemWdata;
    end
  end

  // Reference model: decides, per idle cycle, who is served and when it completes.
  initial begin
    bit pick_d;
    cyc = 0; free_cyc = 0; last_d = 1'b0; win_lo = 1; win_hi = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        i_q.delete();
        d_q.delete();
        free_cyc = cyc + 1;
        last_d = 1'b0;
        win_lo = 1; win_hi = 0;
        exp_we = 1'b0;
        exp_memaddr = '0; exp_memwdata = '0;
        exp_irdata = '0; exp_drdata = '0;
        mon_on = 1'b1;
      end else if (mon_on && cyc >= free_cyc && (bus.IReqF || bus.DReqM)) begin
        pick_d = bus.DReqM && (!bus.IReqF || !last_d);
        last_d = pick_d;
        win_lo = cyc + 1;
        win_hi = cyc + LAT;
        free_cyc = cyc + LAT + 2;
        if (pick_d) begin
          exp_memaddr  = bus.DAddrM;
          exp_memwdata = bus.DWdataM;
          exp_we       = bus.DWeM;
          if (bus.DWeM) begin
            ref_mem[bus.DAddrM[9:2]] = bus.DWdataM;
            d_q.push_back('{cyc + LAT + 1, 32'h0, 1'b1});
          end else begin
            d_q.push_back('{cyc + LAT + 1, ref_mem[bus.DAddrM[9:2]], 1'b0});
          end
        end else begin
          exp_memaddr = bus.IAddrF;
          exp_we      = 1'b0;
          i_q.push_back('{cyc + LAT + 1, ref_mem[bus.IAddrF[9:2]], 1'b0});
        end
      end
      cyc++;
    end
  end

  // Monitor: pops expectations when a Ready is due and checks every output.
  always @(negedge clk) begin
    bit   exp_ir, exp_dr, in_win;
    exp_t e;
    if (mon_on) begin
      exp_ir = (i_q.size() > 0 && i_q[0].cyc == cyc);
      exp_dr = (d_q.size() > 0 && d_q[0].cyc == cyc);
      if (exp_ir) begin
        e = i_q.pop_front();
        exp_irdata = e.data;
      end
      if (exp_dr) begin
        e = d_q.pop_front();
        if (!e.store) exp_drdata = e.data;
      end
      in_win = (cyc >= win_lo) && (cyc <= win_hi);
      chk_bit("IReadyF", bus.IReadyF, exp_ir);
      chk_bit("DReadyM", bus.DReadyM, exp_dr);
      chk_word("IRdataF", bus.IRdataF, exp_irdata);
      chk_word("DRdataM", bus.DRdataM, exp_drdata);
      chk_bit("MemEn", bus.MemEn, in_win);
      chk_bit("MemWe", bus.MemWe, in_win && exp_we);
      chk_word("MemAddr", bus.MemAddr, exp_memaddr);
      chk_word("MemWdata", bus.MemWdata, exp_memwdata);
      chk_bit("StallF", bus.StallF, bus.IReqF && !exp_ir);
      chk_bit("StallM", bus.StallM, bus.DReqM && !exp_dr);
    end
  end

  function automatic logic [31:0] rand_addr();
    return $urandom() & 32'hffff_fffc;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_i(input logic [31:0] a, input bit jitter);
    int n;
    bit done;
    bus.IReqF = 1'b1;
    bus.IAddrF = a;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.IReadyF === 1'b1) begin
        done = 1'b1;
      end else if (++n > 400) begin
        checks++;
        errors++;
        $display("FAIL fetch_timeout addr %h: got no IReadyF, required one within 400 cycles", a);
        done = 1'b1;
      end else if (jitter && $urandom_range(0, 7) == 0) begin
        bus.IAddrF = rand_addr();
      end
    end
    @(posedge clk);
    #1;
    bus.IReqF = 1'b0;
  endtask

  task automatic do_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit jitter);
    int n;
    bit done;
    bus.DReqM = 1'b1;
    bus.DWeM = we;
    bus.DAddrM = a;
    bus.DWdataM = wd;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.DReadyM === 1'b1) begin
        done = 1'b1;
      end else if (++n > 400) begin
        checks++;
        errors++;
        $display("FAIL data_timeout addr %h: got no DReadyM, required one within 400 cycles", a);
        done = 1'b1;
      end else if (jitter && $urandom_range(0, 7) == 0) begin
        bus.DAddrM = rand_addr();
        bus.DWdataM = $urandom();
      end
    end
    @(posedge clk);
    #1;
    bus.DReqM = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom();
      ref_mem[k] = mem[k];
    end
    reset = 1'b1;
    bus.IReqF = 1'b0; bus.IAddrF = '0;
    bus.DReqM = 1'b0; bus.DWeM = 1'b0; bus.DAddrM = '0; bus.DWdataM = '0;

    // Reset held two cycles while requests toggle randomly.
    repeat (2) begin
      bus.IReqF = 1'($urandom_range(0, 1));
      bus.DReqM = 1'($urandom_range(0, 1));
      bus.IAddrF = rand_addr();
      bus.DAddrM = rand_addr();
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    bus.IReqF = 1'b0;
    bus.DReqM = 1'b0;
    idle(3);

    // Single fetch.
    mem[8'h10] = 32'hdead_beef;
    ref_mem[8'h10] = 32'hdead_beef;
    do_i(32'h40, 1'b0);
    idle(3);

    // Simultaneous fetch and load: data goes first.
    fork
      do_i(32'h80, 1'b0);
      do_d(1'b0, 32'h200, 32'h0, 1'b0);
    join
    idle(2);

    // Store, then read back through the fetch port.
    do_d(1'b1, 32'h100, 32'h1234_5678, 1'b0);
    idle(1);
    do_i(32'h100, 1'b0);
    idle(2);

    // Both requesters held continuously: grants alternate.
    fork
      begin
        repeat (4) do_i(rand_addr(), 1'b0);
      end
      begin
        repeat (4) do_d(1'b0, rand_addr(), 32'h0, 1'b0);
      end
    join
    idle(3);

    // Reset during the second busy cycle of a load whose address changed mid-access.
    bus.DReqM = 1'b1; bus.DWeM = 1'b0; bus.DAddrM = 32'h300;
    @(posedge clk); #1;
    bus.DAddrM = 32'h3f0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.DReqM = 1'b0;
    idle(4);

    // Random traffic with input jitter and occasional resets.
    rnd_busy = 1'b1;
    fork
      begin
        fork
          begin
            repeat (60) begin
              idle($urandom_range(0, 3));
              do_i(rand_addr(), 1'b1);
            end
          end
          begin
            repeat (60) begin
              idle($urandom_range(0, 3));
              do_d(1'($urandom_range(0, 1)), rand_addr(), $urandom(), 1'b1);
            end
          end
        join
        rnd_busy = 1'b0;
      end
      begin
        while (rnd_busy) begin
          @(posedge clk);
          #1;
          if ($urandom_range(0, 149) == 0) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
          end
        end
      end
    join
    idle(LAT + 4);

    chk_word("pending_responses", 32'(i_q.size() + d_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
